// File: rtl/exepipe_pkg.sv
// Shared opcode encoding and helpers for the staged execution lane.
package exepipe_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpSll  = 4'd5,
    OpSrl  = 4'd6,
    OpSra  = 4'd7,
    OpSlt  = 4'd8,
    OpSltu = 4'd9
  } op_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/exepipe_alu.sv
// Combinational integer ALU; unknown opcodes give a zero result and raise illegal_o.
module exepipe_alu
  import exepipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              illegal_o
);

  localparam int unsigned ShW = $clog2(DATA_W);

  logic [ShW-1:0] shamt;
  assign shamt = b_i[ShW-1:0];

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OpAdd:   result_o = a_i + b_i;
      OpSub:   result_o = a_i - b_i;
      OpAnd:   result_o = a_i & b_i;
      OpOr:    result_o = a_i | b_i;
      OpXor:   result_o = a_i ^ b_i;
      OpSll:   result_o = a_i << shamt;
      OpSrl:   result_o = a_i >> shamt;
      OpSra:   result_o = $unsigned($signed(a_i) >>> shamt);
      OpSlt:   result_o = {{(DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OpSltu:  result_o = {{(DATA_W-1){1'b0}}, a_i < b_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_pipe_staged.sv
// Integer lane: bypass mux into an RR/EX register, ALU, EXE_LATENCY result stages (last = WB).
// Optional EXEPIPE_PERF_EN adds saturating issue/flush/done counters.
module exec_pipe_staged
  import exepipe_pkg::*;
#(
  parameter int unsigned NUM_BYPASS  = 4,
  parameter int unsigned EXE_LATENCY = 1,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PHY_W       = 7,
  parameter int unsigned AL_W        = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         recoverFlag_i,
  input  logic                         exceptionFlag_i,
  input  logic                         laneActive_i,
  input  logic                         issueValid_i,
  input  logic [OP_W-1:0]              issueOp_i,
  input  logic [AL_W-1:0]              issueAlId_i,
  input  logic [PHY_W-1:0]             issueDest_i,
  input  logic [PHY_W-1:0]             issueSrc1_i,
  input  logic [PHY_W-1:0]             issueSrc2_i,
  input  logic                         issueSrc2Imm_i,
  input  logic [DATA_W-1:0]            issueImm_i,
  output logic [PHY_W-1:0]             phySrc1_o,
  output logic [PHY_W-1:0]             phySrc2_o,
  input  logic [DATA_W-1:0]            src1Data_i,
  input  logic [DATA_W-1:0]            src2Data_i,
  input  logic [NUM_BYPASS-1:0]        bypValid_i,
  input  logic [NUM_BYPASS*PHY_W-1:0]  bypTag_i,
  input  logic [NUM_BYPASS*DATA_W-1:0] bypData_i,
  output logic                         bypassValid_o,
  output logic [PHY_W-1:0]             bypassTag_o,
  output logic [DATA_W-1:0]            bypassData_o,
  output logic                         ctrlValid_o,
  output logic [AL_W-1:0]              ctrlAlId_o,
  output logic                         ctrlExcp_o,
  output logic                         busy_o
`ifdef EXEPIPE_PERF_EN
  ,
  output logic [31:0]                  perfIssued_o,
  output logic [31:0]                  perfFlushed_o,
  output logic [31:0]                  perfDone_o
`endif
);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [AL_W-1:0]   alId;
    logic [PHY_W-1:0]  dest;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } rr_t;

  typedef struct packed {
    logic              valid;
    logic [AL_W-1:0]   alId;
    logic [PHY_W-1:0]  dest;
    logic [DATA_W-1:0] result;
    logic              excp;
  } exe_stage_t;

  logic flush, accept;
  assign flush  = recoverFlag_i | exceptionFlag_i;
  assign accept = issueValid_i & laneActive_i & ~flush;

  assign phySrc1_o = issueSrc1_i;
  assign phySrc2_o = issueSrc2_i;

  // Descending scan so the lowest-index matching channel wins.
  logic [DATA_W-1:0] op1, op2;
  always_comb begin
    op1 = src1Data_i;
    op2 = issueSrc2Imm_i ? issueImm_i : src2Data_i;
    for (int i = int'(NUM_BYPASS) - 1; i >= 0; i--) begin
      if (bypValid_i[i] && bypTag_i[i*PHY_W +: PHY_W] == issueSrc1_i) begin
        op1 = bypData_i[i*DATA_W +: DATA_W];
      end
      if (!issueSrc2Imm_i && bypValid_i[i] && bypTag_i[i*PHY_W +: PHY_W] == issueSrc2_i) begin
        op2 = bypData_i[i*DATA_W +: DATA_W];
      end
    end
  end

  rr_t        rr_d, rr_q;
  exe_stage_t stg_d [EXE_LATENCY];
  exe_stage_t stg_q [EXE_LATENCY];

  logic [DATA_W-1:0] alu_res;
  logic              alu_ill;

  exepipe_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i      (rr_q.op),
    .a_i       (rr_q.a),
    .b_i       (rr_q.b),
    .result_o  (alu_res),
    .illegal_o (alu_ill)
  );

  always_comb begin
    rr_d = '{valid: accept, op: issueOp_i, alId: issueAlId_i, dest: issueDest_i,
             a: op1, b: op2};
    stg_d    = stg_q;
    stg_d[0] = '{valid: rr_q.valid, alId: rr_q.alId, dest: rr_q.dest,
                 result: alu_res, excp: alu_ill};
    for (int i = 1; i < int'(EXE_LATENCY); i++) begin
      stg_d[i] = stg_q[i-1];
    end
    for (int i = 0; i < int'(EXE_LATENCY); i++) begin
      stg_d[i].valid = stg_d[i].valid & ~flush;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q  <= '0;
      stg_q <= '{default: '0};
    end else begin
      rr_q  <= rr_d;
      stg_q <= stg_d;
    end
  end

  // Last stage is the writeback register; data is gated so idle outputs read as zero.
  exe_stage_t wb;
  assign wb = stg_q[EXE_LATENCY-1];

  assign bypassValid_o = wb.valid & ~wb.excp;
  assign bypassTag_o   = bypassValid_o ? wb.dest : '0;
  assign bypassData_o  = bypassValid_o ? wb.result : '0;
  assign ctrlValid_o   = wb.valid;
  assign ctrlAlId_o    = wb.valid ? wb.alId : '0;
  assign ctrlExcp_o    = wb.valid & wb.excp;

  always_comb begin
    busy_o = rr_q.valid;
    for (int i = 0; i < int'(EXE_LATENCY); i++) begin
      busy_o = busy_o | stg_q[i].valid;
    end
  end

`ifdef EXEPIPE_PERF_EN
  logic [31:0] n_live;
  logic [31:0] perf_issued_q, perf_flushed_q, perf_done_q;

  always_comb begin
    n_live = 32'(rr_q.valid);
    for (int i = 0; i < int'(EXE_LATENCY); i++) begin
      n_live = n_live + 32'(stg_q[i].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_q  <= '0;
      perf_flushed_q <= '0;
      perf_done_q    <= '0;
    end else begin
      perf_issued_q  <= sat_add32(perf_issued_q, 32'(accept));
      perf_flushed_q <= sat_add32(perf_flushed_q, flush ? n_live : 32'd0);
      perf_done_q    <= sat_add32(perf_done_q, 32'(wb.valid));
    end
  end

  assign perfIssued_o  = perf_issued_q;
  assign perfFlushed_o = perf_flushed_q;
  assign perfDone_o    = perf_done_q;
`endif

endmodule

// File: tb/tb_exec_pipe_staged.sv
// Scoreboard bench: driver pushes expected completions, negedge monitor pops and compares.
module tb_exec_pipe_staged;

  localparam int LAT = 3;
  localparam int NB  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        recoverFlag, exceptionFlag, laneActive, issueValid;
  logic [3:0]  issueOp;
  logic [6:0]  issueAlId, issueDest, issueSrc1, issueSrc2;
  logic        issueSrc2Imm;
  logic [31:0] issueImm;
  logic [6:0]  phySrc1, phySrc2;
  logic [31:0] src1Data, src2Data;
  logic [NB-1:0]    bypValid;
  logic [NB*7-1:0]  bypTag;
  logic [NB*32-1:0] bypData;
  logic        bypassValid, ctrlValid, ctrlExcp, busy;
  logic [6:0]  bypassTag, ctrlAlId;
  logic [31:0] bypassData;
`ifdef EXEPIPE_PERF_EN
  logic [31:0] perfIssued, perfFlushed, perfDone;
`endif

  logic [31:0] prf [128];
  assign src1Data = prf[phySrc1];
  assign src2Data = prf[phySrc2];

  always #5 clk = ~clk;

  exec_pipe_staged #(
    .NUM_BYPASS  (NB),
    .EXE_LATENCY (LAT),
    .DATA_W      (32),
    .PHY_W       (7),
    .AL_W        (7)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .recoverFlag_i   (recoverFlag),
    .exceptionFlag_i (exceptionFlag),
    .laneActive_i    (laneActive),
    .issueValid_i    (issueValid),
    .issueOp_i       (issueOp),
    .issueAlId_i     (issueAlId),
    .issueDest_i     (issueDest),
    .issueSrc1_i     (issueSrc1),
    .issueSrc2_i     (issueSrc2),
    .issueSrc2Imm_i  (issueSrc2Imm),
    .issueImm_i      (issueImm),
    .phySrc1_o       (phySrc1),
    .phySrc2_o       (phySrc2),
    .src1Data_i      (src1Data),
    .src2Data_i      (src2Data),
    .bypValid_i      (bypValid),
    .bypTag_i        (bypTag),
    .bypData_i       (bypData),
    .bypassValid_o   (bypassValid),
    .bypassTag_o     (bypassTag),
    .bypassData_o    (bypassData),
    .ctrlValid_o     (ctrlValid),
    .ctrlAlId_o      (ctrlAlId),
    .ctrlExcp_o      (ctrlExcp),
    .busy_o          (busy)
`ifdef EXEPIPE_PERF_EN
    ,
    .perfIssued_o    (perfIssued),
    .perfFlushed_o   (perfFlushed),
    .perfDone_o      (perfDone)
`endif
  );

  typedef struct {
    int          cyc;
    logic [6:0]  alid;
    logic [6:0]  dest;
    logic [31:0] res;
    logic        excp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the opcode definitions; returns {illegal, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0: return {1'b0, a + b};
      4'd1: return {1'b0, a - b};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b0, a << sh};
      4'd6: return {1'b0, a >> sh};
      4'd7: return {1'b0, $unsigned($signed(a) >>> sh)};
      4'd8: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      4'd9: return {1'b0, 31'd0, (a < b)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [6:0] tag, input logic [31:0] prfv);
    for (int i = 0; i < NB; i++) begin
      if (bypValid[i] && bypTag[i*7 +: 7] == tag) return bypData[i*32 +: 32];
    end
    return prfv;
  endfunction

  // Called with this cycle's inputs already driven; ends one cycle later at posedge+1.
  task automatic cycle_end();
    bit          acc, fl;
    logic [31:0] a, b;
    logic [32:0] r;
    exp_t        e;
    #1;
    fl  = recoverFlag || exceptionFlag;
    acc = issueValid && laneActive && !fl;
    chk("phy_src1", {57'd0, phySrc1}, {57'd0, issueSrc1});
    chk("phy_src2", {57'd0, phySrc2}, {57'd0, issueSrc2});
    if (acc) begin
      a = pick(issueSrc1, prf[issueSrc1]);
      b = issueSrc2Imm ? issueImm : pick(issueSrc2, prf[issueSrc2]);
      r = ref_alu(issueOp, a, b);
      e.cyc = cyc + LAT + 1; e.alid = issueAlId; e.dest = issueDest;
      e.res = r[31:0]; e.excp = r[32];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl) q.delete();
    issueValid = 1'b0; recoverFlag = 1'b0; exceptionFlag = 1'b0; bypValid = '0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [6:0] s1, input logic [6:0] s2,
                       input logic imm_en, input logic [31:0] imm, input logic [6:0] dst,
                       input logic [6:0] alid);
    issueValid = 1'b1; issueOp = op; issueSrc1 = s1; issueSrc2 = s2;
    issueSrc2Imm = imm_en; issueImm = imm; issueDest = dst; issueAlId = alid;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_end();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_busy, exp_v;
      exp_busy = 1'b0;
      foreach (q[i]) if (q[i].cyc <= cyc + LAT) exp_busy = 1'b1;
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      exp_v = (q.size() > 0) && (q[0].cyc == cyc);
      chk("ctrl_valid", {63'd0, ctrlValid}, {63'd0, exp_v});
      if (exp_v) begin
        chk("ctrl_alid", {57'd0, ctrlAlId}, {57'd0, q[0].alid});
        chk("ctrl_excp", {63'd0, ctrlExcp}, {63'd0, q[0].excp});
        chk("byp_valid", {63'd0, bypassValid}, {63'd0, !q[0].excp});
        chk("byp_tag", {57'd0, bypassTag}, {57'd0, q[0].excp ? 7'd0 : q[0].dest});
        chk("byp_data", {32'd0, bypassData}, {32'd0, q[0].excp ? 32'd0 : q[0].res});
        void'(q.pop_front());
      end else begin
        chk("idle_outputs", {16'd0, bypassValid, bypassTag, bypassData, ctrlAlId, ctrlExcp},
            64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) prf[i] = $urandom;
    reset = 1'b1; recoverFlag = 1'b0; exceptionFlag = 1'b0; laneActive = 1'b1;
    issueValid = 1'b0; issueOp = '0; issueAlId = '0; issueDest = '0; issueSrc1 = '0;
    issueSrc2 = '0; issueSrc2Imm = 1'b0; issueImm = '0; bypValid = '0; bypTag = '0;
    bypData = '0;

    // Reset: outputs zero even with an issue presented.
    repeat (2) @(posedge clk);
    #1;
    issueValid = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_ctrl_valid", {63'd0, ctrlValid}, 64'd0);
    chk("reset_byp_valid", {63'd0, bypassValid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_data", {32'd0, bypassData}, 64'd0);
    issueValid = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // ADD 5 + 7 through the PRF, latency LAT+1.
    prf[3] = 32'd5; prf[4] = 32'd7;
    drive(4'd0, 7'd3, 7'd4, 1'b0, 32'd0, 7'd10, 7'd1);
    cycle_end();
    idle(LAT);
    chk("t1_add_valid", {63'd0, bypassValid}, 64'd1);
    chk("t1_add_data", {32'd0, bypassData}, 64'd12);
    idle(2);

    // Two matching bypass channels: lowest index wins over PRF.
    prf[6] = 32'd99;
    bypTag = {NB{7'h7F}};
    bypTag[1*7 +: 7] = 7'd6; bypData[1*32 +: 32] = 32'd10;
    bypTag[3*7 +: 7] = 7'd6; bypData[3*32 +: 32] = 32'd20;
    drive(4'd0, 7'd6, 7'd0, 1'b1, 32'd0, 7'd11, 7'd2);
    bypValid = 4'b1010;
    cycle_end();
    idle(LAT);
    chk("t2_bypass_data", {32'd0, bypassData}, 64'd10);
    idle(2);

    // Back-to-back issue.
    for (int i = 0; i < 8; i++) begin
      drive(4'($urandom_range(0, 9)), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
            1'b0, 32'd0, 7'(i + 20), 7'(i + 40));
      cycle_end();
    end
    idle(LAT + 2);

    // Flush with three ops in flight plus one issuing.
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 7'(i), 7'(i + 1), 1'b0, 32'd0, 7'(i + 50), 7'(i + 60));
      cycle_end();
    end
    drive(4'd1, 7'd1, 7'd2, 1'b0, 32'd0, 7'd53, 7'd63);
    recoverFlag = 1'b1;
    cycle_end();
    chk("t4_busy_after_flush", {63'd0, busy}, 64'd0);
    chk("t4_ctrl_after_flush", {63'd0, ctrlValid}, 64'd0);
    idle(LAT + 2);

    // Illegal opcode, then SRA of a negative value.
    drive(4'hF, 7'd1, 7'd2, 1'b0, 32'd0, 7'd70, 7'd71);
    cycle_end();
    prf[8] = 32'h8000_0000;
    drive(4'd7, 7'd8, 7'd0, 1'b1, 32'd4, 7'd72, 7'd73);
    cycle_end();
    idle(LAT - 1);
    chk("t5_illegal_ctrl", {63'd0, ctrlValid}, 64'd1);
    chk("t5_illegal_excp", {63'd0, ctrlExcp}, 64'd1);
    chk("t5_illegal_byp", {63'd0, bypassValid}, 64'd0);
    idle(1);
    chk("t5_sra_data", {32'd0, bypassData}, 64'hF800_0000);
    idle(2);

    // Lane deactivates with work in flight: new issues dropped, old ones complete.
    for (int i = 0; i < 2; i++) begin
      drive(4'd2, 7'(i + 3), 7'(i + 5), 1'b0, 32'd0, 7'(i + 80), 7'(i + 90));
      cycle_end();
    end
    laneActive = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      drive(4'd0, 7'd1, 7'd1, 1'b0, 32'd0, 7'd99, 7'd99);
      cycle_end();
    end
    chk("t6_busy_drained", {63'd0, busy}, 64'd0);
    laneActive = 1'b1;

    // Random traffic with bypasses, lane toggling and occasional flushes.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        drive(($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) :
              4'($urandom_range(0, 9)),
              7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              $urandom, 7'($urandom), 7'($urandom));
      end
      for (int c = 0; c < NB; c++) begin
        bypTag[c*7 +: 7]   = 7'($urandom_range(0, 7));
        bypData[c*32 +: 32] = $urandom;
      end
      bypValid = NB'($urandom);
      laneActive = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 1) != 0) recoverFlag = 1'b1;
        else exceptionFlag = 1'b1;
      end
      cycle_end();
    end
    laneActive = 1'b1;
    idle(LAT + 4);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
